// File: rtl/color_trace_pkg.sv
// Shared constants, trace record payload and the saturating overrun adder for color_trace.
package color_trace_pkg;

  localparam int unsigned COLOR_BW   = 64;
  localparam int unsigned REC_CHAN_W = 4;
  localparam int unsigned REC_TS_W   = 32;
  localparam int unsigned OVR_W      = 16;

  typedef struct packed {
    logic [REC_CHAN_W-1:0] chan;
    logic [COLOR_BW-1:0]   color;
    logic [REC_TS_W-1:0]   tstamp;
  } trace_rec_t;

  // Adds up to 16 simultaneous overruns and clamps at all-ones.
  function automatic logic [OVR_W-1:0] sat_add_ovr(input logic [OVR_W-1:0] acc,
                                                   input logic [4:0]       inc);
    logic [OVR_W:0] sum;
    sum = {1'b0, acc} + {{(OVR_W-4){1'b0}}, inc};
    return sum[OVR_W] ? {OVR_W{1'b1}} : sum[OVR_W-1:0];
  endfunction

endpackage

// File: rtl/color_trace_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last granted channel.
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  last_i,
  output logic           gnt_vld_c,
  output logic [NCH-1:0] gnt_oh_c,
  output logic [CW-1:0]  gnt_idx_c
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_vld_c = 1'b0;
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (32'(last_i) + k) % NCH;
      if (!gnt_vld_c && req_i[CW'(idx)]) begin
        gnt_vld_c           = 1'b1;
        gnt_oh_c[CW'(idx)]  = 1'b1;
        gnt_idx_c           = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/color_trace.sv
// Timestamps value changes on NCH color buses, holds one record per channel and
// drains them round-robin through a registered valid/ready port.
module color_trace
  import color_trace_pkg::*;
#(
  parameter int unsigned BW  = COLOR_BW,
  parameter int unsigned NCH = 4,
  parameter int unsigned TSW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NCH*BW-1:0]       col_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NCH)-1:0]  out_chan,
  output logic [BW-1:0]           out_color,
  output logic [TSW-1:0]          out_time,
  output logic [NCH-1:0]          pending,
  output logic [OVR_W-1:0]        overrun_cnt
);

  localparam int unsigned CW = $clog2(NCH);

  logic [TSW-1:0]          ts_q, ts_d;
  logic [NCH-1:0][BW-1:0]  prev_q;
  logic [NCH-1:0][BW-1:0]  slot_color_q, slot_color_d;
  logic [NCH-1:0][TSW-1:0] slot_time_q, slot_time_d;
  logic [NCH-1:0]          pend_q, pend_d;
  logic [CW-1:0]           last_q, last_d;
  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_chan_q, out_chan_d;
  logic [BW-1:0]           out_color_q, out_color_d;
  logic [TSW-1:0]          out_time_q, out_time_d;
  logic [OVR_W-1:0]        ovr_q, ovr_d;

  logic [NCH-1:0] change, granted, ovr;
  logic [NCH-1:0] gnt_oh;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_vld, grant;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req_i     (pend_q),
    .last_i    (last_q),
    .gnt_vld_c (gnt_vld),
    .gnt_oh_c  (gnt_oh),
    .gnt_idx_c (gnt_idx)
  );

  // The output register may take a new record whenever it is empty or being accepted.
  assign grant   = gnt_vld && (!out_valid_q || out_ready);
  assign granted = grant ? gnt_oh : '0;

  always_comb begin
    change = '0;
    for (int i = 0; i < NCH; i++)
      change[i] = en && (col_in[i*BW +: BW] != prev_q[i]);
  end

  always_comb begin
    ts_d         = ts_q + TSW'(1);
    slot_color_d = slot_color_q;
    slot_time_d  = slot_time_q;
    pend_d       = pend_q;
    ovr          = '0;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    out_color_d  = out_color_q;
    out_time_d   = out_time_q;

    // A record leaving through the grant is never counted as lost.
    for (int i = 0; i < NCH; i++) begin
      if (change[i]) begin
        slot_color_d[i] = col_in[i*BW +: BW];
        slot_time_d[i]  = ts_q;
        pend_d[i]       = 1'b1;
        ovr[i]          = pend_q[i] && !granted[i];
      end else if (granted[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    ovr_d = sat_add_ovr(ovr_q, 5'($countones(ovr)));

    if (grant) begin
      out_valid_d = 1'b1;
      out_chan_d  = gnt_idx;
      out_color_d = slot_color_q[gnt_idx];
      out_time_d  = slot_time_q[gnt_idx];
      last_d      = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q         <= '0;
      prev_q       <= '0;
      slot_color_q <= '0;
      slot_time_q  <= '0;
      pend_q       <= '0;
      last_q       <= CW'(NCH-1);
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      out_color_q  <= '0;
      out_time_q   <= '0;
      ovr_q        <= '0;
    end else begin
      ts_q         <= ts_d;
      prev_q       <= col_in;
      slot_color_q <= slot_color_d;
      slot_time_q  <= slot_time_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      out_color_q  <= out_color_d;
      out_time_q   <= out_time_d;
      ovr_q        <= ovr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_chan    = out_chan_q;
  assign out_color   = out_color_q;
  assign out_time    = out_time_q;
  assign pending     = pend_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_color_trace.sv
// Scoreboard bench for color_trace: a mailbox-per-channel reference model predicts
// every record; a second instance with a 4-bit timestamp exercises counter wrap.
module tb_color_trace;
  import color_trace_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned BW  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic [BW-1:0] col [NCH];
  logic [NCH*BW-1:0] col_in;

  logic          out_valid, w_valid;
  logic [1:0]    out_chan, w_chan;
  logic [63:0]   out_color, w_color;
  logic [31:0]   out_time;
  logic [3:0]    w_time;
  logic [3:0]    pending, w_pending;
  logic [15:0]   overrun_cnt, w_ovr;

  int total = 0;
  int bad = 0;

  assign col_in = {col[3], col[2], col[1], col[0]};

  always #5 clk = ~clk;

  color_trace #(.BW(BW), .NCH(NCH), .TSW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .col_in(col_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_color(out_color), .out_time(out_time), .pending(pending),
    .overrun_cnt(overrun_cnt)
  );

  color_trace #(.BW(BW), .NCH(NCH), .TSW(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .col_in(col_in),
    .out_valid(w_valid), .out_ready(out_ready), .out_chan(w_chan),
    .out_color(w_color), .out_time(w_time), .pending(w_pending),
    .overrun_cnt(w_ovr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: newest unsent change per channel, a one-deep output buffer,
  // round-robin service. Records are queued in the order they reach the output.
  trace_rec_t  box [NCH];
  bit          has [NCH];
  logic [63:0] m_prev [NCH];
  bit          m_vld;
  int          m_last;
  int          m_pick;
  logic [31:0] m_ts;
  int          m_ovr;
  trace_rec_t  exp_q [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        has[c]    = 1'b0;
        m_prev[c] = '0;
      end
      m_vld  = 1'b0;
      m_last = NCH - 1;
      m_ts   = '0;
      m_ovr  = 0;
      exp_q.delete();
    end else begin
      m_pick = -1;
      if (!m_vld || out_ready)
        for (int k = 1; k <= NCH; k++)
          if (m_pick < 0 && has[(m_last + k) % NCH]) m_pick = (m_last + k) % NCH;
      if (m_pick >= 0) begin
        exp_q.push_back(box[m_pick]);
        has[m_pick] = 1'b0;
        m_vld  = 1'b1;
        m_last = m_pick;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (en && col[c] != m_prev[c]) begin
          if (has[c]) m_ovr = (m_ovr < 65535) ? m_ovr + 1 : 65535;
          box[c].chan   = 4'(c);
          box[c].color  = col[c];
          box[c].tstamp = m_ts;
          has[c] = 1'b1;
        end
        m_prev[c] = col[c];
      end
      m_ts = m_ts + 32'd1;
    end
  end

  // Monitor: state flags every cycle, record contents on each accepted transfer.
  initial begin
    trace_rec_t e;
    logic [3:0] hv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) hv[c] = has[c];
      check("out_valid", 64'(out_valid), 64'(m_vld));
      check("pending", 64'(pending), 64'(hv));
      check("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
      check("w_valid", 64'(w_valid), 64'(m_vld));
      check("w_pending", 64'(w_pending), 64'(hv));
      check("w_overrun", 64'(w_ovr), 64'(m_ovr));
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rec_chan", 64'(out_chan), 64'(e.chan));
          check("rec_color", out_color, e.color);
          check("rec_time", 64'(out_time), 64'(e.tstamp));
          check("w_chan", 64'(w_chan), 64'(e.chan));
          check("w_color", w_color, e.color);
          check("w_time_wrap", 64'(w_time), 64'(e.tstamp[3:0]));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) col[c] = '0;
    tick(2);
    check("rst_out_chan", 64'(out_chan), 64'd0);
    check("rst_out_color", out_color, 64'd0);
    check("rst_out_time", 64'(out_time), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) col[c] = '0;
    out_ready = 1'b1;
    do_reset();

    // ch0 0 -> 5 captured with ts=3, presented next cycle, gone the one after.
    en = 1'b1;
    tick(3);
    col[0] = 64'h5;
    tick();
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_chan", 64'(out_chan), 64'd0);
    check("t1_color", out_color, 64'h5);
    check("t1_time", 64'(out_time), 64'd3);
    tick();
    check("t1_valid_drop", 64'(out_valid), 64'd0);

    // All channels change at ts=10: records 0..3 on consecutive cycles.
    do_reset();
    tick(10);
    for (int c = 0; c < NCH; c++) col[c] = 64'h100 + 64'(c);
    tick();
    for (int c = 0; c < NCH; c++) begin
      tick();
      check("t2_chan", 64'(out_chan), 64'(c));
      check("t2_time", 64'(out_time), 64'd10);
    end

    // ch2 A, B, C while stalled: A sits in the output, B is lost, C drains next.
    tick(2);
    out_ready = 1'b0;
    col[2] = 64'hA;
    tick();
    col[2] = 64'hB;
    tick();
    col[2] = 64'hC;
    tick();
    check("t3_out_color", out_color, 64'hA);
    check("t3_overrun", 64'(overrun_cnt), 64'd1);
    out_ready = 1'b1;
    tick();
    check("t3_next_color", out_color, 64'hC);
    check("t3_next_chan", 64'(out_chan), 64'd2);
    tick(2);

    // Load two slots, then disable detection; ch1 toggles are ignored, slots still drain.
    out_ready = 1'b0;
    col[0] = col[0] ^ 64'h1;
    col[3] = col[3] ^ 64'h1;
    tick(2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      col[1] = col[1] ^ 64'hF0;
      tick();
    end
    out_ready = 1'b1;
    tick(3);
    en = 1'b1;
    tick(3);
    check("t4_valid_idle", 64'(out_valid), 64'd0);
    check("t4_pending_idle", 64'(pending), 64'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0)
          col[c] = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      tick();
    end
    rst_n = 1'b1;

    // Overrun stress: every channel changes every cycle with the consumer stalled.
    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 16500; i++) begin
      for (int c = 0; c < NCH; c++) col[c] = col[c] + 64'd1;
      tick();
    end
    check("t5_overrun_sat", 64'(overrun_cnt), 64'hFFFF);
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) col[c] = col[c] + 64'd1;
    tick();
    rst_n = 1'b1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_chan", 64'(out_chan), 64'd0);
    check("t5_rst_color", out_color, 64'd0);
    check("t5_rst_time", 64'(out_time), 64'd0);
    check("t5_rst_pending", 64'(pending), 64'd0);
    check("t5_rst_overrun", 64'(overrun_cnt), 64'd0);
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NCH; c++) col[c] = col[c] + 64'd1;
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end

    // Drain everything and confirm nothing predicted was left unseen.
    en = 1'b0;
    out_ready = 1'b1;
    tick(20);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
